qspi_sram_ctrl: RTL and testbench

QSPI master that performs single-byte reads and writes to the PMOD QSPI SRAM on behalf of the Levenshtein engine. It sits between the core's memory request port and the `uio` pins: `ss_n` on `uio_out[0]`, `sck` on `uio_out[3]`, and `sio[3:0]` on `{uio[5], uio[4], uio[2], uio[1]}`. The SRAM is operated in QPI mode, so every nibble, including the command, travels on all four lines. Each access is one complete chip-select frame.

---
 rtl/qspi_sram_ctrl.sv | 165 ++++++++++++++++
 tb/tb_qspi_sram_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_sram_ctrl.sv
// QPI-mode master for single-byte reads and writes to a QSPI SRAM.
// Every access is one chip-select frame: command, 24-bit address, optional dummy, one data byte.
module qspi_sram_ctrl #(
  parameter int DUMMY_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        sck,
  output logic        ss_n,
  output logic [3:0]  sio_out,
  input  logic [3:0]  sio_in,
  output logic [3:0]  sio_oe
);

  localparam int NPULSE = 10 + DUMMY_CYCLES;
  localparam int CNT_W  = $clog2(NPULSE + 1);

  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(7 + DUMMY_CYCLES);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(9);
  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(9 + DUMMY_CYCLES);

  localparam logic [7:0] CMD_WRITE = 8'h38;
  localparam logic [7:0] CMD_READ  = 8'hEB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_DESELECT
  } state_t;

  state_t           state_reg, state_next;
  logic             phase_reg, phase_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             desel_reg, desel_next;
  logic             write_reg;
  logic [39:0]      shift_reg;
  logic [3:0]       rx_hi_reg;
  logic             drive_en;
  logic [CNT_W-1:0] last_cnt;

  assign last_cnt = write_reg ? WR_LAST : RD_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      phase_reg <= 1'b0;
      cnt_reg   <= '0;
      desel_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
      desel_reg <= desel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    cnt_next   = cnt_reg;
    desel_next = desel_reg;
    req_ready  = 1'b0;
    ss_n       = 1'b0;
    sck        = 1'b0;
    drive_en   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        ss_n      = 1'b1;
        if (req_valid) state_next = S_SELECT;
      end

      S_SELECT: begin
        drive_en   = 1'b1;
        phase_next = 1'b0;
        cnt_next   = '0;
        state_next = S_CMD;
      end

      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        // phase 0 is the sck-low half where sio_out changes; the pulse completes after phase 1
        sck        = phase_reg;
        drive_en   = (state_reg != S_DUMMY) && !(state_reg == S_DATA && !write_reg);
        phase_next = ~phase_reg;
        if (phase_reg) begin
          cnt_next = cnt_reg + 1'b1;
          case (state_reg)
            S_CMD: begin
              if (cnt_reg == CMD_LAST) state_next = S_ADDR;
            end
            S_ADDR: begin
              if (cnt_reg == ADDR_LAST)
                state_next = (write_reg || DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
            end
            S_DUMMY: begin
              if (cnt_reg == DUMMY_LAST) state_next = S_DATA;
            end
            default: begin
              if (cnt_reg == last_cnt) begin
                state_next = S_DESELECT;
                desel_next = 1'b0;
              end
            end
          endcase
        end
      end

      S_DESELECT: begin
        ss_n       = 1'b1;
        desel_next = 1'b1;
        if (desel_reg) state_next = S_IDLE;
      end

      default: begin
        ss_n       = 1'b1;
        state_next = S_IDLE;
      end
    endcase

    sio_oe  = {4{drive_en}};
    sio_out = drive_en ? shift_reg[39:36] : 4'h0;
  end

  // The whole outgoing frame is preloaded and shifted one nibble per completed sck pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg <= 1'b0;
      shift_reg <= '0;
      rx_hi_reg <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (req_valid && req_ready) begin
        write_reg <= req_write;
        shift_reg <= {(req_write ? CMD_WRITE : CMD_READ), req_addr, req_wdata};
      end else if (sck) begin
        shift_reg <= {shift_reg[35:0], 4'h0};
        if (state_reg == S_DATA && !write_reg) begin
          if (cnt_reg == RD_LAST) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= {rx_hi_reg, sio_in};
          end else begin
            rx_hi_reg <= sio_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_sram_ctrl.sv
// Bench for qspi_sram_ctrl: two instances (6 and 4 dummy pulses), an SRAM model on the pins,
// and a frame-level reference model checked every cycle.
module tb_qspi_sram_ctrl;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_write [NI];
  logic [23:0] req_addr  [NI];
  logic [7:0]  req_wdata [NI];
  logic        rsp_valid [NI];
  logic [7:0]  rsp_rdata [NI];
  logic        sck       [NI];
  logic        ss_n      [NI];
  logic [3:0]  sio_out   [NI];
  logic [3:0]  sio_in    [NI];
  logic [3:0]  sio_oe    [NI];

  qspi_sram_ctrl #(.DUMMY_CYCLES(6)) dut6 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .sck(sck[0]), .ss_n(ss_n[0]), .sio_out(sio_out[0]), .sio_in(sio_in[0]), .sio_oe(sio_oe[0])
  );

  qspi_sram_ctrl #(.DUMMY_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .sck(sck[1]), .ss_n(ss_n[1]), .sio_out(sio_out[1]), .sio_in(sio_in[1]), .sio_oe(sio_oe[1])
  );

  function automatic int dv(input int i);
    return (i == 0) ? 6 : 4;
  endfunction

  function automatic int npulse(input bit w, input int i);
    return w ? 10 : 10 + dv(i);
  endfunction

  function automatic logic [3:0] frame_nib(input bit w, input logic [23:0] a,
                                           input logic [7:0] d, input int p);
    logic [39:0] f;
    f = {(w ? 8'h38 : 8'hEB), a, d};
    return f[39 - 4*p -: 4];
  endfunction

  // ---------------- reference model: frame offset k since accept ----------------
  bit          m_busy [NI];
  int          m_k    [NI];
  bit          m_w    [NI];
  logic [23:0] m_a    [NI];
  logic [7:0]  m_d    [NI];
  logic [7:0]  m_rd   [NI];
  logic [7:0]  m_last [NI];
  int          m_txn  [NI] = '{0, 0};
  bit   [7:0]  exp_mem  [NI][256];
  bit   [7:0]  sram_mem [NI][256];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n[i]) begin
        m_busy[i] = 1'b0;
        m_last[i] = 8'h00;
      end else if (m_busy[i]) begin
        if (m_k[i] == 3 + 2*npulse(m_w[i], i)) begin
          m_busy[i] = 1'b0;
          if (!m_w[i]) m_last[i] = m_rd[i];
        end else begin
          m_k[i]++;
        end
      end else if (req_valid[i]) begin
        m_busy[i] = 1'b1;
        m_k[i]    = 1;
        m_w[i]    = req_write[i];
        m_a[i]    = req_addr[i];
        m_d[i]    = req_wdata[i];
        m_txn[i]++;
        if (req_write[i]) exp_mem[i][req_addr[i][7:0]] = req_wdata[i];
        m_rd[i] = exp_mem[i][req_addr[i][7:0]];
      end
    end
  end

  // ---------------- QPI SRAM pin model ----------------
  int          s_n   [NI];
  logic [7:0]  s_cmd [NI];
  logic [23:0] s_a   [NI];
  logic [3:0]  s_hi  [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (ss_n[i] !== 1'b0) begin
        s_n[i]    = 0;
        sio_in[i] = 4'h0;
      end else if (sck[i] === 1'b1) begin
        if (s_n[i] < 2) s_cmd[i] = {s_cmd[i][3:0], sio_out[i]};
        else if (s_n[i] < 8) s_a[i] = {s_a[i][19:0], sio_out[i]};
        else if (s_cmd[i] == 8'h38 && s_n[i] == 8) s_hi[i] = sio_out[i];
        else if (s_cmd[i] == 8'h38 && s_n[i] == 9) sram_mem[i][s_a[i][7:0]] = {s_hi[i], sio_out[i]};
        s_n[i]++;
      end else if (s_cmd[i] == 8'hEB && s_n[i] == 8 + dv(i)) begin
        sio_in[i] = sram_mem[i][s_a[i][7:0]][7:4];
      end else if (s_cmd[i] == 8'hEB && s_n[i] == 9 + dv(i)) begin
        sio_in[i] = sram_mem[i][s_a[i][7:0]][3:0];
      end
    end
  end

  // ---------------- compare ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] lit_w   [10] = '{4'h3, 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'hA, 4'h5};
  logic [3:0] lit_r   [8]  = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3};
  int         lit_rsp [NI] = '{34, 30};

  task automatic chk(input string name, input int i, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s inst=%0d txn=%0d k=%0d got=%0h want=%0h",
               name, i, m_txn[i], m_k[i], act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int k, n, p;
      int e_rdy, e_ss, e_sck, e_oe, e_sio, e_rv, e_rd;
      e_rdy = 1; e_ss = 1; e_sck = 0; e_oe = 0; e_sio = 0; e_rv = 0;
      e_rd  = int'(m_last[i]);
      if (!rst_n[i]) begin
        e_rd = 0;
      end else if (m_busy[i]) begin
        k = m_k[i];
        n = npulse(m_w[i], i);
        e_rdy = 0;
        if (k <= 1 + 2*n) begin
          e_ss  = 0;
          p     = (k < 2) ? 0 : (k - 2) / 2;
          e_sck = (k >= 2 && (k - 2) % 2 == 1) ? 1 : 0;
          e_oe  = (p < 8 || m_w[i]) ? 15 : 0;
          e_sio = (e_oe != 0) ? int'(frame_nib(m_w[i], m_a[i], m_d[i], p)) : 0;
        end else begin
          e_rv = (!m_w[i] && k == 2 + 2*n) ? 1 : 0;
          if (!m_w[i]) e_rd = int'(m_rd[i]);
        end
        // hand-computed pins for the first write/read pair
        if (i == 0 && m_txn[i] == 1 && k >= 3 && k <= 21 && k % 2 == 1)
          chk("lit_wr_nibble", i, int'(sio_out[i]), int'(lit_w[(k - 3) / 2]));
        if (i == 0 && m_txn[i] == 2 && k >= 3 && k <= 17 && k % 2 == 1)
          chk("lit_rd_nibble", i, int'(sio_out[i]), int'(lit_r[(k - 3) / 2]));
        if (i == 0 && m_txn[i] == 2 && k == 17) chk("lit_oe_before", i, int'(sio_oe[i]), 15);
        if (i == 0 && m_txn[i] == 2 && k == 18) chk("lit_oe_fall", i, int'(sio_oe[i]), 0);
        if (i == 0 && m_txn[i] == 2 && k == 34) chk("lit_rdata_a5", i, int'(rsp_rdata[i]), 8'hA5);
        if (i == 1 && m_txn[i] == 2 && k == 30) chk("lit_rdata_96", i, int'(rsp_rdata[i]), 8'h96);
        if (rsp_valid[i] === 1'b1) chk("lit_rsp_cycle", i, k, lit_rsp[i]);
      end
      chk("req_ready", i, int'(req_ready[i]), e_rdy);
      chk("ss_n",      i, int'(ss_n[i]),      e_ss);
      chk("sck",       i, int'(sck[i]),       e_sck);
      chk("sio_oe",    i, int'(sio_oe[i]),    e_oe);
      chk("sio_out",   i, int'(sio_out[i]),   e_sio);
      chk("rsp_valid", i, int'(rsp_valid[i]), e_rv);
      chk("rsp_rdata", i, int'(rsp_rdata[i]), e_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(input int i);
    int t;
    t = 0;
    while (req_ready[i] !== 1'b1) begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        $display("FAIL timeout inst=%0d req_ready never returned", i);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic issue(input int i, input bit w, input logic [23:0] a, input logic [7:0] d);
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    wait_ready(i);
    @(negedge clk);
    req_valid[i] = 1'b0;
    $display("txn inst=%0d %s addr=%06h wdata=%02h", i, w ? "write" : "read", a, d);
  endtask

  task automatic wait_idle(input int i);
    @(negedge clk);
    wait_ready(i);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_n[i]     = 1'b0;
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 24'h0;
      req_wdata[i] = 8'h0;
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    issue(0, 1'b1, 24'h000123, 8'hA5); wait_idle(0);
    issue(0, 1'b0, 24'h000123, 8'h00); wait_idle(0);

    // back-to-back with req_valid held: write then read
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 24'h000045; req_wdata[0] = 8'h5C;
    wait_ready(0);
    @(negedge clk);
    req_write[0] = 1'b0;
    $display("txn inst=0 write addr=000045 wdata=5c (valid held)");
    @(negedge clk);
    wait_ready(0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    $display("txn inst=0 read addr=000045 (back-to-back)");
    wait_idle(0);

    // reset in cycle 12 of a read, then a fresh read
    issue(0, 1'b0, 24'h000123, 8'h00);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 rst_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    issue(0, 1'b0, 24'h000045, 8'h00); wait_idle(0);

    // request inputs wiggling while busy must not disturb the frame
    issue(0, 1'b1, 24'h000077, 8'h3E);
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      req_valid[0] = t[0];
      req_write[0] = t[1];
      req_addr[0]  = 24'($urandom);
      req_wdata[0] = 8'($urandom);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_idle(0);
    issue(0, 1'b0, 24'h000077, 8'h00); wait_idle(0);

    // four dummy pulses
    issue(1, 1'b1, 24'h000010, 8'h96); wait_idle(1);
    issue(1, 1'b0, 24'h000010, 8'h00); wait_idle(1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
